// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
// Used by the responder top and its storage array.
package dmem_pkg;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/data_memory_responder_array.sv
// 2**ADDR_W x 16 storage, one synchronous port with byte write enables.
// Read data register clears on any cycle that is not a read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_i,
  input  logic                   we_i,
  input  logic [1:0]             be_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [DMEM_DATA_W-1:0] wdata_i,
  output logic [DMEM_DATA_W-1:0] rdata_o
);

  logic [DMEM_DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DMEM_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data-memory responder: handshake, wait states, 1-cycle response.
// DMEM_BYTE_WRITE_EN enables per-byte writes via req_be.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [DMEM_DATA_W-1:0] req_addr,
  input  logic [DMEM_DATA_W-1:0] req_wdata,
  input  logic [1:0]             req_be,
  output logic                   resp_valid,
  output logic [DMEM_DATA_W-1:0] resp_rdata,
  output logic                   resp_err,
  output logic                   busy
);

  localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : DMEM_CNT_W'(WAIT_CYCLES - 1);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  dmem_state_t            state_q;
  logic [DMEM_CNT_W-1:0]  cnt_q;
  logic                   we_q;
  logic [DMEM_DATA_W-1:0] addr_q;
  logic [DMEM_DATA_W-1:0] wdata_q;
  logic [1:0]             be_q;
  logic                   req_ready_q;
  logic                   busy_q;
  logic                   resp_valid_q;
  logic                   resp_err_q;

  logic                   accept;
  logic                   go_resp;
  logic                   acc_we;
  logic [DMEM_DATA_W-1:0] acc_addr;
  logic [DMEM_DATA_W-1:0] acc_wdata;
  logic [1:0]             acc_be;
  logic [1:0]             be_eff;
  logic                   in_range;
  logic                   mem_en;

  assign accept  = (state_q == IDLE) && req_valid;
  assign go_resp = (accept && NO_WAIT) ||
                   ((state_q == WAIT) && (cnt_q == '0));

  // Zero-wait accesses use the live request; otherwise the held copy.
  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == IDLE) ? req_be    : be_q;

  assign in_range = (acc_addr[DMEM_DATA_W-1:ADDR_W] == '0);
  assign mem_en   = go_resp && in_range;

`ifdef DMEM_BYTE_WRITE_EN
  assign be_eff = acc_be;
`else
  logic unused_be;
  assign unused_be = ^acc_be;
  assign be_eff    = 2'b11;
`endif

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .en_i   (mem_en),
    .we_i   (acc_we),
    .be_i   (be_eff),
    .addr_i (acc_addr[ADDR_W-1:0]),
    .wdata_i(acc_wdata),
    .rdata_o(resp_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt_q       <= CNT_INIT;
            if (NO_WAIT) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= ~in_range;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ~in_range;
          end else begin
            cnt_q <= cnt_q - DMEM_CNT_W'(1);
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          busy_q       <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

endmodule
